temp_monitor: RTL and testbench

TEMP_MONITOR -- requirements
Module: temp_monitor

---
 rtl/temp_monitor_pkg.sv | 24 ++
 rtl/temp_monitor_stats.sv | 90 +++++++++
 rtl/temp_monitor.sv | 150 +++++++++++++++
 tb/tb_temp_monitor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/temp_monitor_pkg.sv
// Shared types and constants for the temperature monitor: poll FSM states,
// CSR word addresses and the sensor code offset.
package temp_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UPDATE = 2'd3
  } poll_state_e;

  localparam logic [1:0] CSR_ADDR_STATUS = 2'd0;
  localparam logic [1:0] CSR_ADDR_MINMAX = 2'd1;
  localparam logic [1:0] CSR_ADDR_COUNTS = 2'd2;
  localparam logic [1:0] CSR_ADDR_CTRL   = 2'd3;

  // Sensor codes carry degrees C biased by this amount
  localparam logic [7:0] CODE_OFFSET = 8'd128;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/temp_monitor_stats.sv
// Sample statistics: block averaging, min/max tracking and the hysteretic
// over-temperature alarm that only moves when a new average is produced.
module temp_stats
  import temp_monitor_pkg::*;
#(
  parameter int unsigned AvgLog2 = 3,
  parameter logic [6:0]  AlarmHi = 7'd85,
  parameter logic [6:0]  AlarmLo = 7'd80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       sample_valid,
  input  logic [7:0] code,
  output logic [7:0] avg,
  output logic       avg_valid,
  output logic [7:0] min_code,
  output logic [7:0] max_code,
  output logic       alarm,
  output logic       alarm_n
);

  localparam int unsigned AccW   = 8 + AvgLog2;
  localparam logic [7:0]  HiCode = {1'b0, AlarmHi} + CODE_OFFSET;
  localparam logic [7:0]  LoCode = {1'b0, AlarmLo} + CODE_OFFSET;

  logic [AccW-1:0]    acc_r;
  logic [AccW-1:0]    acc_sum_s;
  logic [AvgLog2-1:0] blk_cnt_r;
  logic               first_r;
  logic               block_done_s;
  logic [7:0]         new_avg_s;

  always_comb begin
    acc_sum_s    = acc_r + AccW'(code);
    new_avg_s    = acc_sum_s[AvgLog2 +: 8];
    block_done_s = sample_valid && (blk_cnt_r == {AvgLog2{1'b1}});
  end

  // The block count wraps to zero by itself on the last sample of a block
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_r     <= '0;
      blk_cnt_r <= '0;
    end else if (sample_valid) begin
      blk_cnt_r <= blk_cnt_r + AvgLog2'(1);
      acc_r     <= block_done_s ? '0 : acc_sum_s;
    end
  end

  // A clear keeps avg and alarm so the last known state stays visible
  always_ff @(posedge clk) begin
    if (reset) begin
      avg       <= 8'd0;
      avg_valid <= 1'b0;
      alarm     <= 1'b0;
      alarm_n   <= 1'b1;
    end else if (clear) begin
      avg_valid <= 1'b0;
    end else if (block_done_s) begin
      avg       <= new_avg_s;
      avg_valid <= 1'b1;
      if (new_avg_s >= HiCode) begin
        alarm   <= 1'b1;
        alarm_n <= 1'b0;
      end else if (new_avg_s <= LoCode) begin
        alarm   <= 1'b0;
        alarm_n <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      min_code <= 8'd0;
      max_code <= 8'd0;
      first_r  <= 1'b1;
    end else if (sample_valid) begin
      if (first_r) begin
        min_code <= code;
        max_code <= code;
        first_r  <= 1'b0;
      end else begin
        if (code < min_code) min_code <= code;
        if (code > max_code) max_code <= code;
      end
    end
  end

endmodule

// File: rtl/temp_monitor.sv
// Periodic Avalon-MM temperature poller with a small CSR block; statistics
// and alarm generation live in temp_stats.
module temp_monitor
  import temp_monitor_pkg::*;
#(
  parameter logic [23:0] PollCycles  = 24'd1_000_000,
  parameter int unsigned AvgLog2     = 3,
  parameter logic [6:0]  AlarmHi     = 7'd85,
  parameter logic [6:0]  AlarmLo     = 7'd80,
  parameter logic [7:0]  WaitTimeout = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic        m_readdatavalid,
  input  logic [15:0] m_readdata,
  input  logic [1:0]  csr_address,
  input  logic        csr_read,
  output logic [31:0] csr_readdata,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic        alarm,
  output logic        alarm_n
);

  poll_state_e state_r, state_next_s;
  logic [23:0] poll_cnt_r;
  logic [7:0]  wait_cnt_r;
  logic [8:0]  sample_r;
  logic        enable_r;
  logic [15:0] sample_cnt_r;
  logic [7:0]  invalid_cnt_r;
  logic [7:0]  timeout_cnt_r;
  logic        timeout_s;
  logic        ctrl_wr_s;
  logic        clear_s;
  logic        sample_ok_s;
  logic        sample_bad_s;
  logic [7:0]  avg_s;
  logic        avg_valid_s;
  logic [7:0]  min_s;
  logic [7:0]  max_s;
  logic        unused_s;

  assign unused_s = ^{csr_writedata[31:2], m_readdata[15:9]};

  always_comb begin
    state_next_s = state_r;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable_r && (poll_cnt_r == 24'd0)) state_next_s = ST_READ;
        else                                    state_next_s = ST_IDLE;
      end
      ST_READ: begin
        if (!m_waitrequest) state_next_s = ST_WAIT;
        else                state_next_s = ST_READ;
      end
      ST_WAIT: begin
        if (m_readdatavalid) begin
          state_next_s = ST_UPDATE;
        end else if (wait_cnt_r == (WaitTimeout - 8'd1)) begin
          state_next_s = ST_IDLE;
          timeout_s    = 1'b1;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_UPDATE: state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // A clear landing on the UPDATE cycle discards that sample completely
  always_comb begin
    ctrl_wr_s    = csr_write && (csr_address == CSR_ADDR_CTRL);
    clear_s      = ctrl_wr_s && csr_writedata[0];
    sample_ok_s  = (state_r == ST_UPDATE) && sample_r[8] && !clear_s;
    sample_bad_s = (state_r == ST_UPDATE) && !sample_r[8] && !clear_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      poll_cnt_r <= PollCycles - 24'd1;
      wait_cnt_r <= 8'd0;
      sample_r   <= 9'd0;
      m_read     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      m_read  <= (state_next_s == ST_READ);
      if ((state_r == ST_IDLE) && enable_r && (poll_cnt_r != 24'd0))
        poll_cnt_r <= poll_cnt_r - 24'd1;
      else
        poll_cnt_r <= PollCycles - 24'd1;
      wait_cnt_r <= (state_r == ST_WAIT) ? wait_cnt_r + 8'd1 : 8'd0;
      if ((state_r == ST_WAIT) && m_readdatavalid) sample_r <= m_readdata[8:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_s) begin
      sample_cnt_r  <= 16'd0;
      invalid_cnt_r <= 8'd0;
      timeout_cnt_r <= 8'd0;
    end else begin
      if (sample_ok_s)  sample_cnt_r  <= sample_cnt_r + 16'd1;
      if (sample_bad_s) invalid_cnt_r <= sat_inc8(invalid_cnt_r);
      if (timeout_s)    timeout_cnt_r <= sat_inc8(timeout_cnt_r);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_r     <= 1'b1;
      csr_readdata <= 32'd0;
    end else begin
      if (ctrl_wr_s) enable_r <= csr_writedata[1];
      if (csr_read) begin
        case (csr_address)
          CSR_ADDR_STATUS: csr_readdata <= {alarm, avg_valid_s, 22'd0, avg_s};
          CSR_ADDR_MINMAX: csr_readdata <= {16'd0, max_s, min_s};
          CSR_ADDR_COUNTS: csr_readdata <= {timeout_cnt_r, invalid_cnt_r, sample_cnt_r};
          CSR_ADDR_CTRL:   csr_readdata <= {30'd0, enable_r, 1'b0};
          default:         csr_readdata <= 32'd0;
        endcase
      end
    end
  end

  temp_stats #(
    .AvgLog2 (AvgLog2),
    .AlarmHi (AlarmHi),
    .AlarmLo (AlarmLo)
  ) u_stats (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear_s),
    .sample_valid (sample_ok_s),
    .code         (sample_r[7:0]),
    .avg          (avg_s),
    .avg_valid    (avg_valid_s),
    .min_code     (min_s),
    .max_code     (max_s),
    .alarm        (alarm),
    .alarm_n      (alarm_n)
  );

endmodule

// File: tb/tb_temp_monitor.sv
// Directed bench for temp_monitor: an Avalon slave model driven inline and a
// CSR scoreboard that queues expectations when a read is issued.
module tb_temp_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_read;
  logic        m_waitrequest;
  logic        m_readdatavalid;
  logic [15:0] m_readdata;
  logic [1:0]  csr_address;
  logic        csr_read;
  logic [31:0] csr_readdata;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic        alarm;
  logic        alarm_n;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  temp_monitor #(.PollCycles(24'd4)) dut (
    .clk             (clk),
    .reset           (reset),
    .m_read          (m_read),
    .m_waitrequest   (m_waitrequest),
    .m_readdatavalid (m_readdatavalid),
    .m_readdata      (m_readdata),
    .csr_address     (csr_address),
    .csr_read        (csr_read),
    .csr_readdata    (csr_readdata),
    .csr_write       (csr_write),
    .csr_writedata   (csr_writedata),
    .alarm           (alarm),
    .alarm_n         (alarm_n)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic csr_rd(input logic [1:0] a, input logic [31:0] expv, input string tag);
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    csr_address = a;
    csr_read    = 1'b1;
    @(negedge clk);
    csr_read = 1'b0;
    check(tag_q.pop_front(), csr_readdata, exp_q.pop_front());
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    @(negedge clk);
    csr_write     = 1'b0;
    csr_writedata = 32'd0;
  endtask

  task automatic wait_mread();
    int guard = 0;
    while (m_read !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (m_read !== 1'b1) check("mread_seen", {31'd0, m_read}, 32'd1);
  endtask

  // Returns on the negedge where the DUT sits in UPDATE
  task automatic serve_read(input logic [15:0] d, input int ws, output int hi);
    hi = 0;
    wait_mread();
    for (int i = 0; i < ws; i++) begin
      hi += int'(m_read);
      @(negedge clk);
    end
    hi += int'(m_read);
    m_waitrequest = 1'b0;
    @(negedge clk);
    m_waitrequest = 1'b1;
    hi += int'(m_read);
    m_readdatavalid = 1'b1;
    m_readdata      = d;
    @(negedge clk);
    m_readdatavalid = 1'b0;
    m_readdata      = 16'd0;
  endtask

  task automatic serve(input logic [15:0] d, input int n);
    int hi;
    repeat (n) begin
      serve_read(d, 0, hi);
      @(negedge clk);
    end
  endtask

  function automatic logic [15:0] vd(input logic [7:0] code);
    return {7'd0, 1'b1, code};
  endfunction

  initial begin
    int hi;
    int bad;
    reset = 1'b1; m_waitrequest = 1'b1; m_readdatavalid = 1'b0; m_readdata = 16'd0;
    csr_address = 2'd0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_mread", {31'd0, m_read}, 32'd0);
    check("rst_alarm", {30'd0, alarm, alarm_n}, 32'd1);
    check("rst_rdata", csr_readdata, 32'd0);
    csr_rd(2'd0, 32'h0000_0000, "rst_status");
    csr_rd(2'd1, 32'h0000_0000, "rst_minmax");
    csr_rd(2'd2, 32'h0000_0000, "rst_counts");
    csr_rd(2'd3, 32'h0000_0002, "rst_ctrl");

    serve(vd(8'hD2), 8);
    csr_rd(2'd0, 32'h4000_00D2, "avg82_status");
    csr_rd(2'd2, 32'h0000_0008, "avg82_counts");
    csr_rd(2'd1, 32'h0000_D2D2, "avg82_minmax");
    check("avg82_alarm", {31'd0, alarm}, 32'd0);

    serve(vd(8'hD5), 8);
    csr_rd(2'd0, 32'hC000_00D5, "avg85_status");
    check("avg85_pins", {30'd0, alarm, alarm_n}, 32'd2);
    serve(vd(8'hD1), 8);
    csr_rd(2'd0, 32'hC000_00D1, "avg81_hold");
    serve(vd(8'hD0), 4);
    check("mid_block_alarm", {31'd0, alarm}, 32'd1);
    serve(vd(8'hD0), 4);
    csr_rd(2'd0, 32'h4000_00D0, "avg80_status");
    check("avg80_pins", {30'd0, alarm, alarm_n}, 32'd1);
    csr_rd(2'd2, 32'h0000_0020, "cnt32");
    csr_rd(2'd1, 32'h0000_D5D0, "minmax_d5d0");

    csr_wr(2'd0, 32'hFFFF_FFFF);
    csr_wr(2'd1, 32'hFFFF_FFFF);
    csr_wr(2'd2, 32'hFFFF_FFFF);
    csr_rd(2'd2, 32'h0000_0020, "ro_counts");
    csr_rd(2'd3, 32'h0000_0002, "ro_ctrl");

    csr_wr(2'd3, 32'h0000_0003);
    csr_rd(2'd2, 32'h0000_0000, "clr_counts");
    csr_rd(2'd1, 32'h0000_0000, "clr_minmax");
    csr_rd(2'd0, 32'h0000_00D0, "clr_status");
    for (int i = 0; i < 4; i++) serve(vd((i % 2 == 0) ? 8'hA0 : 8'hC0), 1);
    csr_rd(2'd1, 32'h0000_C0A0, "alt_minmax");
    serve(16'h0040, 1);
    serve_read(vd(8'hC0), 3, hi);
    @(negedge clk);
    check("waitreq_hi", hi, 32'd4);
    csr_rd(2'd2, 32'h0001_0005, "invalid_counts");
    csr_rd(2'd1, 32'h0000_C0A0, "invalid_minmax");

    wait_mread();
    m_waitrequest = 1'b0;
    @(negedge clk);
    m_waitrequest = 1'b1;
    repeat (253) @(negedge clk);
    csr_rd(2'd2, 32'h0001_0005, "tmo_before");
    csr_rd(2'd2, 32'h0001_0005, "tmo_edge");
    csr_rd(2'd2, 32'h0101_0005, "tmo_after");
    check("tmo_idle", {31'd0, m_read}, 32'd0);

    repeat (8) @(negedge clk);
    csr_wr(2'd3, 32'h0000_0000);
    serve(vd(8'hC0), 1);
    csr_rd(2'd2, 32'h0101_0006, "dis_mid_counts");
    csr_rd(2'd3, 32'h0000_0000, "dis_ctrl");
    bad = 0;
    repeat (20) begin @(negedge clk); bad += int'(m_read); end
    check("dis_mread", bad, 32'd0);
    csr_wr(2'd3, 32'h0000_0002);

    csr_wr(2'd3, 32'h0000_0003);
    serve(vd(8'hD5), 8);
    csr_rd(2'd0, 32'hC000_00D5, "pre_drop_status");
    serve_read(vd(8'hD0), 0, hi);
    csr_wr(2'd3, 32'h0000_0003);
    csr_wr(2'd3, 32'h0000_0000);
    csr_rd(2'd0, 32'h8000_00D5, "drop_status");
    csr_rd(2'd1, 32'h0000_0000, "drop_minmax");
    csr_rd(2'd2, 32'h0000_0000, "drop_counts");
    check("drop_alarm", {31'd0, alarm}, 32'd1);
    bad = 0;
    repeat (100) begin @(negedge clk); bad += int'(m_read); end
    check("off_mread", bad, 32'd0);

    csr_wr(2'd3, 32'h0000_0002);
    wait_mread();
    m_waitrequest = 1'b0;
    @(negedge clk);
    m_waitrequest = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_readdatavalid = 1'b1;
    m_readdata      = vd(8'hD5);
    repeat (2) @(negedge clk);
    m_readdatavalid = 1'b0;
    m_readdata      = 16'd0;
    csr_rd(2'd2, 32'h0000_0000, "mid_rst_counts");
    csr_rd(2'd1, 32'h0000_0000, "mid_rst_minmax");
    csr_rd(2'd0, 32'h0000_0000, "mid_rst_status");
    check("mid_rst_pins", {30'd0, alarm, alarm_n}, 32'd1);
    serve(vd(8'hA0), 1);
    csr_rd(2'd1, 32'h0000_A0A0, "post_rst_minmax");
    csr_rd(2'd2, 32'h0000_0001, "post_rst_counts");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
